prg_cache: RTL and testbench
============================

# prg_cache

Parametrised successor to the single-word PRG bridge between the asynchronous cartridge CPU bus and the SDRAM controller. It holds a direct-mapped cache of `LINES` 16-bit SDRAM words, so repeated CPU reads across several regions are served without new SDRAM requests. Writes go through to SDRAM and update any cached copy. An optional next-word prefetch is available. It sits between the cartridge bus synchronisers and one `sdram_bus` controller port.

## Interface
- `ADDR_BITS`, 23: CPU byte-address width (SDRAM word width + 1).
- `LINES`, 4: cache lines; power of two, 2..64.
- `RD_LATENCY`, 6: cycles from the `ram.req` pulse until `ram.data_read` is valid; `ram.data_read` holds until the next request.
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  synchronous reset, active-low.
- `ram`  `sdram_bus.controller`  —  SDRAM port: `req`, `we`, `address`, `data_write`, `wm`, `data_read`.
- `addr`  in  `ADDR_BITS`  CPU byte address; stable while `oe`/`we` is asserted.
- `data_in`  in  8  CPU write data.
- `data_out`  out  8  CPU read data.
- `oe`  in  1  CPU read strobe; asynchronous.
- `we`  in  1  CPU write strobe; asynchronous.

## Operation
- Word address: `waddr = addr[ADDR_BITS-1:1]`.
- Line index: `idx = waddr[log2(LINES)-1:0]`.
- Tag: `tag = waddr[ADDR_BITS-2:log2(LINES)]`.
- Each line holds `valid`, `tag` and `data[15:0]`.
- `data_out = addr[0] ? line[idx].data[15:8] : line[idx].data[7:0]`. This is purely combinational and tracks `addr` continuously.
- `oe` and `we` each pass through a 4-flop shift register.
  - Read event: taps [3:1] == 3'b011.
  - Write event: taps [3:1] == 3'b100.
- State machine: `IDLE`, `RD_WAIT`, `PF_WAIT` (the last exists only with the macro).
- `IDLE`, read event:
  - Hit (`valid && tag` match): no SDRAM access.
  - Miss: issue a read (`ram.we`=0, `ram.address`=`waddr`, one-cycle `ram.req`), latch `waddr`, load latency counter, go to `RD_WAIT`.
- `IDLE`, write event:
  - Issue one-cycle `ram.req` with `ram.we`=1, `ram.address`=`waddr`, `ram.data_write`={`data_in`,`data_in`}.
  - `ram.wm` = 2'b01 when `addr[0]`=1, 2'b10 when `addr[0]`=0.
  - On a hit, write `data_in` into the matching byte of the line in the same cycle. On a miss, no allocation.
- `RD_WAIT`: when the counter expires, write `ram.data_read` into the latched line, set `valid` and `tag`, then return to `IDLE` (or go to `PF_WAIT` with prefetch).
- Events during `RD_WAIT`/`PF_WAIT` are held in a one-deep pending slot per type and serviced in `IDLE` on the next cycle. Write is serviced before read.
  - A second event of the same type while pending is dropped.
- A write-through to the line being filled in `RD_WAIT` is held pending, so the fill lands first and the pending write then updates the line.

## Timing
- Reset (`rst_n`=0 at a `clk` edge):
  - Outputs: `ram.req`=0, `ram.we`=0, `ram.address`=0, `ram.data_write`=0, `ram.wm`=2'b11.
  - Internal: all `valid`=0, all line data=0 so `data_out`=0, sync registers=0, pending slots cleared, state `IDLE`.
- Reset mid-`RD_WAIT` abandons the fill; the SDRAM response is ignored.
- Event detection: strobe edge to event takes 3 `clk` cycles after the first synchroniser sample.
- Read miss: `ram.req` rises on the cycle after the event. The line is written `RD_LATENCY`+1 cycles after the `req` cycle, and `data_out` is valid the following cycle.
- Read hit: `data_out` is already valid from `addr` alone, with zero cycles of state.
- `ram.req` is high for exactly one cycle per access and never on consecutive cycles.
- Latency counter width is `$clog2(RD_LATENCY+1)`.

## Configuration
- `PRG_CACHE_PREFETCH_EN` defined:
  - After each demand fill, if line `idx(waddr+1)` does not already hold `waddr+1`, the block issues a read of `waddr+1` and fills it in `PF_WAIT` with identical timing.
  - `waddr+1` wraps modulo 2^(`ADDR_BITS`-1).
  - Prefetch never issues from a write.
- `PRG_CACHE_PREFETCH_EN` undefined: no `PF_WAIT`; `RD_WAIT` always returns to `IDLE`.

## Test plan
- Reset, then read `addr`=0x000010 with SDRAM word 0xBEEF → one `req` with `address`=0x000008, `we`=0; after the fill `data_out`=0xEF, and with `addr`=0x000011 `data_out`=0xBE.
- Re-read 0x000010 → no `req`; `data_out`=0xEF.
- Write 0x5A to 0x000011 (line cached) → `req` with `we`=1, `data_write`=0x5A5A, `wm`=2'b01; a following read of 0x000011 issues no `req` and gives `data_out`=0x5A.
- `LINES`=4: read word 0x08, then word 0x0C (same index, different tag) → two `req`s; read 0x08 again → third `req` (eviction).
- Write event during `RD_WAIT` → write `req` issued 1 cycle after `IDLE`, not before the fill completes; `rst_n` pulsed mid-fill → `valid` cleared, no line written.
- `PRG_CACHE_PREFETCH_EN`: read miss of word 0x3FFFFF (`ADDR_BITS`=23) → second `req` with `address`=0x000000; a read of that word afterwards issues no `req`.

Source files
------------

// File: rtl/prg_cache.sv
// Direct-mapped word cache between the cartridge CPU bus and one SDRAM controller port.
// Optional next-word prefetch is enabled by defining PRG_CACHE_PREFETCH_EN.
module prg_cache #(
    parameter int ADDR_BITS  = 23,
    parameter int LINES      = 4,
    parameter int RD_LATENCY = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 ram_req,
    output logic                 ram_we,
    output logic [ADDR_BITS-2:0] ram_address,
    output logic [15:0]          ram_data_write,
    output logic [1:0]           ram_wm,
    input  logic [15:0]          ram_data_read,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [7:0]           data_in,
    output logic [7:0]           data_out,
    input  logic                 oe,
    input  logic                 we
);

    localparam int WA_W  = ADDR_BITS - 1;
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = WA_W - IDX_W;
    localparam int CNT_W = $clog2(RD_LATENCY + 1);

`ifdef PRG_CACHE_PREFETCH_EN
    typedef enum logic [1:0] {IDLE, RD_WAIT, PF_WAIT} state_t;
`else
    typedef enum logic [1:0] {IDLE, RD_WAIT} state_t;
`endif

    state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [WA_W-1:0]  fill_addr, fill_addr_n;
    logic [3:0]       oe_sync, we_sync;

    logic                 rd_pend, wr_pend;
    logic [WA_W-1:0]      rd_pend_addr;
    logic [ADDR_BITS-1:0] wr_pend_addr;
    logic [7:0]           wr_pend_data;

    logic             line_valid [LINES];
    logic [TAG_W-1:0] line_tag   [LINES];
    logic [15:0]      line_data  [LINES];

    logic                 req_n, we_n;
    logic [WA_W-1:0]      address_n;
    logic [15:0]          dw_n;
    logic [1:0]           wm_n;
    logic                 fill_en, bw_en, bw_hi;

    logic                 rd_ev, wr_ev, svc_wr, svc_rd;
    logic                 wr_store, wr_remain, rd_store, rd_remain;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [7:0]           wr_data;
    logic [WA_W-1:0]      rd_waddr, wr_waddr, cpu_waddr;
    logic                 rd_hit, wr_hit;
    logic [IDX_W-1:0]     rd_idx, wr_idx, fill_idx, cpu_idx;

    assign rd_ev = (oe_sync[3:1] == 3'b011);
    assign wr_ev = (we_sync[3:1] == 3'b100);

    // Pending events are serviced before new ones; a write always wins over a read.
    assign svc_wr = (state == IDLE) && !ram_req && (wr_pend || wr_ev);
    assign svc_rd = (state == IDLE) && !ram_req && !svc_wr && (rd_pend || rd_ev);

    assign wr_remain = wr_pend && !svc_wr;
    assign wr_store  = wr_ev && !(svc_wr && !wr_pend) && !wr_remain;
    assign rd_remain = rd_pend && !svc_rd;
    assign rd_store  = rd_ev && !(svc_rd && !rd_pend) && !rd_remain;

    assign wr_addr   = wr_pend ? wr_pend_addr : addr;
    assign wr_data   = wr_pend ? wr_pend_data : data_in;
    assign wr_waddr  = wr_addr[ADDR_BITS-1:1];
    assign rd_waddr  = rd_pend ? rd_pend_addr : addr[ADDR_BITS-1:1];
    assign cpu_waddr = addr[ADDR_BITS-1:1];

    assign rd_idx   = rd_waddr[IDX_W-1:0];
    assign wr_idx   = wr_waddr[IDX_W-1:0];
    assign fill_idx = fill_addr[IDX_W-1:0];
    assign cpu_idx  = cpu_waddr[IDX_W-1:0];

    assign rd_hit = line_valid[rd_idx] && (line_tag[rd_idx] == rd_waddr[WA_W-1:IDX_W]);
    assign wr_hit = line_valid[wr_idx] && (line_tag[wr_idx] == wr_waddr[WA_W-1:IDX_W]);

    assign data_out = addr[0] ? line_data[cpu_idx][15:8] : line_data[cpu_idx][7:0];

`ifdef PRG_CACHE_PREFETCH_EN
    logic [WA_W-1:0]  pf_addr;
    logic [IDX_W-1:0] pf_idx;
    logic             pf_hit;
    assign pf_addr = fill_addr + 1'b1;
    assign pf_idx  = pf_addr[IDX_W-1:0];
    assign pf_hit  = line_valid[pf_idx] && (line_tag[pf_idx] == pf_addr[WA_W-1:IDX_W]);
`endif

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        fill_addr_n = fill_addr;
        req_n       = 1'b0;
        we_n        = ram_we;
        address_n   = ram_address;
        dw_n        = ram_data_write;
        wm_n        = ram_wm;
        fill_en     = 1'b0;
        bw_en       = 1'b0;
        bw_hi       = wr_addr[0];
        case (state)
            IDLE: begin
                if (svc_wr) begin
                    req_n     = 1'b1;
                    we_n      = 1'b1;
                    address_n = wr_waddr;
                    dw_n      = {wr_data, wr_data};
                    wm_n      = wr_addr[0] ? 2'b01 : 2'b10;
                    bw_en     = wr_hit;
                end else if (svc_rd && !rd_hit) begin
                    req_n       = 1'b1;
                    we_n        = 1'b0;
                    address_n   = rd_waddr;
                    wm_n        = 2'b00;
                    fill_addr_n = rd_waddr;
                    cnt_n       = CNT_W'(RD_LATENCY);
                    state_n     = RD_WAIT;
                end
            end
            default: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    fill_en = 1'b1;
                    state_n = IDLE;
`ifdef PRG_CACHE_PREFETCH_EN
                    if (state == RD_WAIT && !pf_hit) begin
                        req_n       = 1'b1;
                        we_n        = 1'b0;
                        address_n   = pf_addr;
                        wm_n        = 2'b00;
                        fill_addr_n = pf_addr;
                        cnt_n       = CNT_W'(RD_LATENCY);
                        state_n     = PF_WAIT;
                    end
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            fill_addr      <= '0;
            oe_sync        <= '0;
            we_sync        <= '0;
            rd_pend        <= 1'b0;
            rd_pend_addr   <= '0;
            wr_pend        <= 1'b0;
            wr_pend_addr   <= '0;
            wr_pend_data   <= '0;
            ram_req        <= 1'b0;
            ram_we         <= 1'b0;
            ram_address    <= '0;
            ram_data_write <= '0;
            ram_wm         <= '1;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            fill_addr      <= fill_addr_n;
            oe_sync        <= {oe_sync[2:0], oe};
            we_sync        <= {we_sync[2:0], we};
            ram_req        <= req_n;
            ram_we         <= we_n;
            ram_address    <= address_n;
            ram_data_write <= dw_n;
            ram_wm         <= wm_n;
            if (wr_store) begin
                wr_pend      <= 1'b1;
                wr_pend_addr <= addr;
                wr_pend_data <= data_in;
            end else begin
                wr_pend <= wr_remain;
            end
            if (rd_store) begin
                rd_pend      <= 1'b1;
                rd_pend_addr <= cpu_waddr;
            end else begin
                rd_pend <= rd_remain;
            end
        end
    end

    // Fill and write-hit never coincide: fills happen only in the wait states.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < unsigned'(LINES); i++) begin
                line_valid[i] <= 1'b0;
                line_tag[i]   <= '0;
                line_data[i]  <= '0;
            end
        end else begin
            if (fill_en) begin
                line_valid[fill_idx] <= 1'b1;
                line_tag[fill_idx]   <= fill_addr[WA_W-1:IDX_W];
                line_data[fill_idx]  <= ram_data_read;
            end
            if (bw_en) begin
                if (bw_hi) line_data[wr_idx][15:8] <= wr_data;
                else       line_data[wr_idx][7:0]  <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_prg_cache.sv
// Self-checking bench for prg_cache: directed test-plan steps plus random CPU traffic
// checked against a word-level cache/memory model.
module tb_prg_cache;

    localparam int ADDR_BITS  = 23;
    localparam int LINES      = 4;
    localparam int RD_LATENCY = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ram_req, ram_we;
    logic [21:0] ram_address;
    logic [15:0] ram_data_write;
    logic [1:0]  ram_wm;
    logic [15:0] ram_data_read = 16'h0000;
    logic [22:0] addr;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        oe, we;

    prg_cache #(.ADDR_BITS(ADDR_BITS), .LINES(LINES), .RD_LATENCY(RD_LATENCY)) dut (
        .clk(clk), .rst_n(rst_n),
        .ram_req(ram_req), .ram_we(ram_we), .ram_address(ram_address),
        .ram_data_write(ram_data_write), .ram_wm(ram_wm), .ram_data_read(ram_data_read),
        .addr(addr), .data_in(data_in), .data_out(data_out), .oe(oe), .we(we)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic        we;
        logic [21:0] a;
        logic [15:0] d;
        logic [1:0]  wm;
        int          cyc;
    } req_t;

    req_t req_q[$];
    req_t exp_q[$];

    // SDRAM contents as seen by the responder, and the bench's own expectation of them.
    logic [15:0] sdram   [int unsigned];
    logic [15:0] ref_mem [int unsigned];

    function automatic logic [15:0] hash16(logic [21:0] a);
        logic [31:0] h;
        h = {10'd0, a} * 32'h9E3779B1;
        return h[22:7] ^ a[15:0];
    endfunction

    function automatic logic [15:0] sd_rd(logic [21:0] a);
        return sdram.exists(int'(a)) ? sdram[int'(a)] : hash16(a);
    endfunction

    function automatic logic [15:0] ref_rd(logic [21:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : hash16(a);
    endfunction

    // SDRAM responder: read data appears RD_LATENCY cycles after the request.
    int          cyc = 0;
    int          b2b = 0;
    logic        prev_req = 1'b0;
    logic        rd_busy = 1'b0;
    int          rd_due = 0;
    logic [21:0] rd_addr = '0;

    always @(negedge clk) begin
        logic [15:0] cur;
        cyc++;
        if (ram_req === 1'b1) begin
            req_q.push_back('{ram_we, ram_address, ram_data_write, ram_wm, cyc});
            if (prev_req) b2b++;
            if (ram_we) begin
                cur = sd_rd(ram_address);
                if (!ram_wm[1]) cur[15:8] = ram_data_write[15:8];
                if (!ram_wm[0]) cur[7:0]  = ram_data_write[7:0];
                sdram[int'(ram_address)] = cur;
            end else begin
                rd_addr       = ram_address;
                rd_due        = cyc + RD_LATENCY;
                rd_busy       = 1'b1;
                ram_data_read = 16'hDEAD;
            end
        end
        prev_req = (ram_req === 1'b1);
        if (rd_busy && cyc == rd_due) begin
            ram_data_read = sd_rd(rd_addr);
            rd_busy       = 1'b0;
        end
    end

    // Cache model: each line remembers which word it holds.
    logic        m_valid [LINES];
    logic [21:0] m_word  [LINES];
    logic [15:0] m_data  [LINES];

    function automatic bit m_hit(logic [21:0] w);
        return m_valid[w % LINES] && (m_word[w % LINES] == w);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) begin
            m_valid[i] = 1'b0;
            m_word[i]  = '0;
            m_data[i]  = '0;
        end
    endtask

    task automatic model_fill(logic [21:0] w);
        m_valid[w % LINES] = 1'b1;
        m_word[w % LINES]  = w;
        m_data[w % LINES]  = ref_rd(w);
        exp_q.push_back('{1'b0, w, 16'h0, 2'b00, 0});
    endtask

    task automatic model_read(logic [21:0] w);
        if (!m_hit(w)) begin
            model_fill(w);
`ifdef PRG_CACHE_PREFETCH_EN
            if (!m_hit(w + 22'd1)) model_fill(w + 22'd1);
`endif
        end
    endtask

    task automatic model_write(logic [22:0] a, logic [7:0] d);
        logic [21:0] w;
        logic [15:0] cur;
        w = a[22:1];
        exp_q.push_back('{1'b1, w, {d, d}, (a[0] ? 2'b01 : 2'b10), 0});
        cur = ref_rd(w);
        if (a[0]) cur[15:8] = d; else cur[7:0] = d;
        ref_mem[int'(w)] = cur;
        if (m_hit(w)) begin
            if (a[0]) m_data[w % LINES][15:8] = d;
            else      m_data[w % LINES][7:0]  = d;
        end
    endtask

    function automatic logic [7:0] m_byte(logic [22:0] a);
        logic [15:0] v;
        v = m_data[a[22:1] % LINES];
        return a[0] ? v[15:8] : v[7:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reqs(input string tag);
        check({tag, "_count"}, req_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < req_q.size(); i++) begin
            check({tag, "_we"}, {31'd0, req_q[i].we}, {31'd0, exp_q[i].we});
            check({tag, "_addr"}, {10'd0, req_q[i].a}, {10'd0, exp_q[i].a});
            if (exp_q[i].we) begin
                check({tag, "_wdata"}, {16'd0, req_q[i].d}, {16'd0, exp_q[i].d});
                check({tag, "_wm"}, {30'd0, req_q[i].wm}, {30'd0, exp_q[i].wm});
            end
        end
        req_q.delete();
        exp_q.delete();
    endtask

    task automatic cpu_read(input logic [22:0] a, input string tag);
        model_read(a[22:1]);
        @(negedge clk);
        addr = a;
        oe   = 1'b1;
        repeat (30) @(negedge clk);
        check({tag, "_dout"}, {24'd0, data_out}, {24'd0, m_byte(a)});
        oe = 1'b0;
        repeat (4) @(negedge clk);
        addr = a ^ 23'd1;
        #1;
        check({tag, "_dout_other"}, {24'd0, data_out}, {24'd0, m_byte(a ^ 23'd1)});
    endtask

    task automatic cpu_write(input logic [22:0] a, input logic [7:0] d);
        model_write(a, d);
        @(negedge clk);
        addr    = a;
        data_in = d;
        we      = 1'b1;
        repeat (2) @(negedge clk);
        we = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        int gap;
        logic [22:0] ra;
        rst_n   = 1'b0;
        oe      = 1'b0;
        we      = 1'b0;
        addr    = '0;
        data_in = '0;
        sdram[8]   = 16'hBEEF;
        ref_mem[8] = 16'hBEEF;
        model_clear();
        repeat (3) @(negedge clk);

        check("rst_req", {31'd0, ram_req}, 32'd0);
        check("rst_we", {31'd0, ram_we}, 32'd0);
        check("rst_address", {10'd0, ram_address}, 32'd0);
        check("rst_wdata", {16'd0, ram_data_write}, 32'd0);
        check("rst_wm", {30'd0, ram_wm}, 32'd3);
        check("rst_dout", {24'd0, data_out}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        cpu_read(23'h000010, "miss_10");
        check("miss_10_byte", {24'd0, m_byte(23'h000010)}, 32'hEF);
        check_reqs("miss_10");
        cpu_read(23'h000010, "hit_10");
        check_reqs("hit_10");
        cpu_write(23'h000011, 8'h5A);
        check_reqs("wr_11");
        cpu_read(23'h000011, "hit_11");
        check("hit_11_byte", {24'd0, m_byte(23'h000011)}, 32'h5A);
        check_reqs("hit_11");

        cpu_read(23'h000018, "evict_c");
        cpu_read(23'h000010, "evict_8");
        check_reqs("evict");

        // Write to the word being filled: it must wait for the fill.
        model_read(22'h40);
        model_write(23'h000080, 8'hC3);
        @(negedge clk);
        addr = 23'h000080;
        oe   = 1'b1;
        repeat (5) @(negedge clk);
        data_in = 8'hC3;
        we      = 1'b1;
        @(negedge clk);
        we = 1'b0;
        repeat (30) @(negedge clk);
        check("wfill_dout", {24'd0, data_out}, 32'hC3);
        oe = 1'b0;
        repeat (4) @(negedge clk);
        gap = (req_q.size() >= 2) ? (req_q[req_q.size()-1].cyc - req_q[0].cyc) : -1;
`ifndef PRG_CACHE_PREFETCH_EN
        check("wfill_gap", gap, RD_LATENCY + 2);
`else
        check("wfill_gap_pf", gap, 2 * RD_LATENCY + 3);
`endif
        check_reqs("wfill");

        // Reset in the middle of a fill discards it.
        @(negedge clk);
        addr = 23'h000100;
        oe   = 1'b1;
        exp_q.push_back('{1'b0, 22'h80, 16'h0, 2'b00, 0});
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        oe    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        repeat (14) @(negedge clk);
        check_reqs("rst_fill");
        check("rst_fill_dout", {24'd0, data_out}, 32'd0);
        check("rst_fill_wm", {30'd0, ram_wm}, 32'd3);
        cpu_read(23'h000100, "refetch");
        check_reqs("refetch");

`ifdef PRG_CACHE_PREFETCH_EN
        cpu_read(23'h7FFFFE, "pf_wrap");
        check_reqs("pf_wrap");
        cpu_read(23'h000000, "pf_hit");
        check_reqs("pf_hit");
`endif

        for (int n = 0; n < 150; n++) begin
            ra = {$urandom_range(0, 23), 1'b0} | 23'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 4) begin
                cpu_write(ra, 8'($urandom));
                check_reqs("rnd_wr");
            end else begin
                cpu_read(ra, "rnd_rd");
                check_reqs("rnd_rd");
            end
        end

        check("req_back_to_back", b2b, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
